// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types for the program-counter unit (pc_unit, ras_stack)
package pc_pkg;

    localparam int PC_W = 15;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_RAS,
        SEL_SEQ
    } pc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] top_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] ptr_inc;

    assign ptr_inc = top_ptr + AW'(1);

    // Entries are not cleared on reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_inc] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push) begin
            top_ptr <= ptr_inc;
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && count != '0) begin
            top_ptr <= top_ptr - AW'(1);
            count   <= count - CW'(1);
        end
    end

    assign top   = mem[top_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with stall, redirect and call/return
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int           N         = 15,
    parameter int           STEP      = 1,
    parameter logic [N-1:0] RESET_VEC = '0,
    parameter int           RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         call,
    input  logic         ret,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] pc_next,
    output logic         ras_empty,
    output logic         ras_full,
    output logic         ret_miss
);

    pc_sel_t      sel;
    logic [N-1:0] pc_seq;
    logic [N-1:0] ras_top;
    logic         ras_empty_i;

    assign pc_seq = pc_out + N'(STEP);

    always_comb begin
        sel = SEL_SEQ;
        if (redirect_valid) begin
            sel = SEL_REDIRECT;
        end else if (stall) begin
            sel = SEL_HOLD;
`ifdef PC_RAS_EN
        end else if (ret && !ras_empty_i) begin
            sel = SEL_RAS;
`endif
        end
    end

    always_comb begin
        pc_next = pc_seq;
        case (sel)
            SEL_REDIRECT: pc_next = redirect_target;
            SEL_HOLD:     pc_next = pc_out;
            SEL_RAS:      pc_next = ras_top;
            default:      pc_next = pc_seq;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out <= RESET_VEC;
        end else begin
            pc_out <= pc_next;
        end
    end

`ifdef PC_RAS_EN
    logic ras_full_i;
    logic ret_miss_d;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (N)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (redirect_valid && call),
        .pop       (sel == SEL_RAS),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty_i),
        .full      (ras_full_i)
    );

    // A ret that finds the stack empty still advances sequentially.
    assign ret_miss_d = ret && !redirect_valid && !stall && ras_empty_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_miss <= 1'b0;
        end else begin
            ret_miss <= ret_miss_d;
        end
    end

    assign ras_empty = ras_empty_i;
    assign ras_full  = ras_full_i;
`else
    logic unused_ras_cfg;

    assign unused_ras_cfg = &{1'b0, call, ret, RAS_DEPTH[0]};
    assign ras_top        = '0;
    assign ras_empty_i    = 1'b1;
    assign ras_empty      = 1'b1;
    assign ras_full       = 1'b0;
    assign ret_miss       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit (with or without PC_RAS_EN)
module tb_pc_unit;
    import pc_pkg::*;

    localparam int   N     = 15;
    localparam int   STEP  = 1;
    localparam pc_t  RVEC  = 15'h0100;
    localparam int   DEPTH = 4;
    localparam int   MODN  = 1 << N;
`ifdef PC_RAS_EN
    localparam bit   RAS_EN = 1'b1;
`else
    localparam bit   RAS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         stall, redirect_valid, call, ret;
    logic [N-1:0] redirect_target;
    logic [N-1:0] pc_out, pc_next;
    logic         ras_empty, ras_full, ret_miss;

    pc_unit #(
        .N         (N),
        .STEP      (STEP),
        .RESET_VEC (RVEC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .pc_out          (pc_out),
        .pc_next         (pc_next),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .ret_miss        (ret_miss)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: PC as an integer, return addresses as a bounded queue.
    int m_pc;
    int m_ras[$];
    bit m_miss;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = int'(RVEC);
        m_ras.delete();
        m_miss = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit r, input int t, input bit c, input bit rt);
        int seq;
        seq    = (m_pc + STEP) % MODN;
        m_miss = 1'b0;
        if (r) begin
            if (c && RAS_EN) begin
                m_ras.push_back(seq);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = t;
        end else if (s) begin
            m_pc = m_pc;
        end else if (rt && RAS_EN && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
        end else begin
            m_miss = rt && RAS_EN;
            m_pc   = seq;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc_out"}, int'(pc_out), m_pc);
        check({tag, ".ras_empty"}, int'(ras_empty), int'(m_ras.size() == 0));
        check({tag, ".ras_full"}, int'(ras_full), int'(m_ras.size() == DEPTH));
        check({tag, ".ret_miss"}, int'(ret_miss), int'(m_miss));
    endtask

    // Drives one cycle's inputs, checks pc_next before the edge and the state after it.
    task automatic cycle(input string tag, input bit s, input bit r, input int t, input bit c, input bit rt);
        stall = s; redirect_valid = r; redirect_target = N'(t); call = c; ret = rt;
        #2;
        model_step(s, r, t, c, rt);
        check({tag, ".pc_next"}, int'(pc_next), m_pc);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    typedef struct {
        bit s; bit r; int t; bit c; bit rt; int exp_pc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; stall = 0; redirect_valid = 0; redirect_target = '0; call = 0; ret = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        check("reset.pc_next", int'(pc_next), int'(RVEC) + 1);
        @(negedge clk);
        reset_n = 1'b1;

        tbl[0]  = '{0, 0, 0,       0, 0, 'h0101};
        tbl[1]  = '{0, 0, 0,       0, 0, 'h0102};
        tbl[2]  = '{0, 0, 0,       0, 0, 'h0103};
        tbl[3]  = '{0, 1, 'h0010,  0, 0, 'h0010};
        tbl[4]  = '{1, 0, 0,       0, 0, 'h0010};
        tbl[5]  = '{1, 0, 0,       0, 0, 'h0010};
        tbl[6]  = '{1, 1, 'h0200,  0, 0, 'h0200};
        tbl[7]  = '{1, 0, 0,       0, 1, 'h0200};
        tbl[8]  = '{0, 0, 0,       1, 0, 'h0201};
        tbl[9]  = '{0, 0, 0,       0, 1, 'h0202};
        tbl[10] = '{0, 1, 'h7FFF,  0, 0, 'h7FFF};
        tbl[11] = '{0, 0, 0,       0, 0, 'h0000};
        tbl[12] = '{0, 1, 'h0123,  0, 1, 'h0123};
        for (int i = 0; i < 13; i++) begin
            cycle($sformatf("vec%0d", i), tbl[i].s, tbl[i].r, tbl[i].t, tbl[i].c, tbl[i].rt);
            check($sformatf("vec%0d.table_pc", i), int'(pc_out), tbl[i].exp_pc);
        end

        // Call then return from 0x0040.
        cycle("cr.go", 0, 1, 'h0040, 0, 0);
        cycle("cr.call", 0, 1, 'h1000, 1, 0);
        check("cr.call_empty", int'(ras_empty), RAS_EN ? 0 : 1);
        cycle("cr.ret", 0, 0, 0, 0, 1);
        check("cr.ret_pc", int'(pc_out), RAS_EN ? 'h0041 : 'h1001);
        check("cr.ret_empty", int'(ras_empty), 1);

        // Five nested calls into a four-deep stack, then five returns.
        for (int k = 1; k <= 5; k++) begin
            cycle("ov.at", 0, 1, k * 'h10, 0, 0);
            cycle("ov.call", 0, 1, 'h0800, 1, 0);
        end
        check("ov.full", int'(ras_full), RAS_EN ? 1 : 0);
        for (int k = 5; k >= 2; k--) begin
            cycle("ov.ret", 0, 0, 0, 0, 1);
            check($sformatf("ov.ret%0d", k), int'(pc_out), RAS_EN ? (k * 'h10 + 1) : int'(pc_out));
        end
        cycle("ov.miss", 0, 0, 0, 0, 1);
        check("ov.miss_flag", int'(ret_miss), RAS_EN ? 1 : 0);
        cycle("ov.after", 0, 0, 0, 0, 0);
        check("ov.miss_clear", int'(ret_miss), 0);

        // Asynchronous reset landing between edges during a call sequence.
        cycle("ar.call1", 0, 1, 'h0300, 1, 0);
        cycle("ar.call2", 0, 1, 'h0400, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("ar.pc_out", int'(pc_out), int'(RVEC));
        check("ar.empty", int'(ras_empty), 1);
        check("ar.full", int'(ras_full), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle("ar.ret", 0, 0, 0, 0, 1);
        check("ar.ret_pc", int'(pc_out), int'(RVEC) + 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit s, r, c, rt;
            int t;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 1) == 1);
            rt = ($urandom_range(0, 2) == 0);
            t  = ($urandom_range(0, 7) == 0) ? (MODN - 1 - int'($urandom_range(0, 2)))
                                             : int'($urandom_range(0, MODN - 1));
            cycle($sformatf("rnd%0d", i), s, r, t, c, rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
